// File: rtl/signed_pow2_divide_pipe_pkg.sv
// Shared definitions for the signed divide-by-2^s pipeline.
//   rnd_mode_t : rounding-mode encoding carried on up_mode
//   MODE_W     : width of the rounding-mode field
// The per-stage payload struct depends on N, so each module declares it
// locally from its own parameters.
package signed_pow2_div_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_FLOOR = 2'd0,
    MODE_TRUNC = 2'd1,
    MODE_ROUND = 2'd2
  } rnd_mode_t;

endpackage

// File: rtl/signed_pow2_divide_pipe_if.sv
// Handshake bundle for signed_pow2_divide_pipe.
//   up_*   : operand side (valid/ready, dividend a, shift s, rounding mode)
//   down_* : result side (valid/ready, quotient, inexact flag)
// slave  = the divide unit, master = the producer/consumer around it.
interface signed_pow2_divide_pipe_if
  import signed_pow2_div_pkg::*;
#(
  parameter int N = 8
);
  localparam int SW = $clog2(N);

  logic              up_valid;
  logic              up_ready;
  logic [N-1:0]      up_a;
  logic [SW-1:0]     up_s;
  logic [MODE_W-1:0] up_mode;
  logic              down_valid;
  logic              down_ready;
  logic [N-1:0]      down_res;
  logic              down_inexact;

  modport slave (
    input  up_valid, up_a, up_s, up_mode, down_ready,
    output up_ready, down_valid, down_res, down_inexact
  );

  modport master (
    output up_valid, up_a, up_s, up_mode, down_ready,
    input  up_ready, down_valid, down_res, down_inexact
  );
endinterface

// File: rtl/signed_pow2_divide_pipe_shift_stage.sv
// One elastic register stage of the shifter: loads when empty or when its
// content leaves this cycle, and arithmetic-shifts the value right by SHIFT
// when the matching bit of the carried shift amount is set.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid_i/in_ready_o, in_pl_i   : upstream handshake + payload
//   out_valid_o/out_ready_i, out_pl_o : downstream handshake + payload
// Payload layout: {value[W-1:0], s[SW-1:0], inexact}.
module pow2_div_shift_stage #(
  parameter int W     = 9,
  parameter int SHIFT = 1,
  parameter int SW    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W+SW:0]  in_pl_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W+SW:0]  out_pl_o
);
  localparam int K = $clog2(SHIFT);

  typedef struct packed {
    logic [W-1:0]  val;
    logic [SW-1:0] s;
    logic          inexact;
  } stage_t;

  stage_t in_pl, pl_d, pl_q;
  logic   vld_q;

  assign in_pl      = stage_t'(in_pl_i);
  assign in_ready_o = !vld_q || out_ready_i;

  always_comb begin
    pl_d     = in_pl;
    if (in_pl.s[K])
      pl_d.val = W'($signed(in_pl.val) >>> SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pl_q  <= '0;
    end else if (in_ready_o) begin
      vld_q <= in_valid_i;
      if (in_valid_i) pl_q <= pl_d;
    end
  end

  assign out_valid_o = vld_q;
  assign out_pl_o    = pl_q;
endmodule

// File: rtl/signed_pow2_divide_pipe.sv
// Pipelined signed divide by 2^s with FLOOR / TRUNC / ROUND rounding.
// Stage P adds a rounding bias to the sign-extended dividend; SW shift
// stages then apply the shift one bit of s at a time. Fully elastic:
// bubbles compress under back-pressure, capacity SW+1, one result/clock.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of signed_pow2_divide_pipe_if
module signed_pow2_divide_pipe
  import signed_pow2_div_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  signed_pow2_divide_pipe_if.slave   bus
);
  localparam int SW = $clog2(N);
  localparam int W  = N + 1;

  typedef struct packed {
    logic [W-1:0]  val;
    logic [SW-1:0] s;
    logic          inexact;
  } stage_t;

  // level 0 is stage P, level k+1 is shift stage Kk
  logic   [SW:0] vld_pipe;
  logic   [SW:0] rdy;
  stage_t [SW:0] pl;

  stage_t       p_d, p_q;
  logic         p_vld_q;
  logic         up_rdy;
  logic [W-1:0] mask;
  logic [W-1:0] bias;

  // The sum cannot overflow W bits: the widest bias is added only to a
  // value whose sign keeps the result in range, so no saturation needed.
  always_comb begin
    mask = (W'(1) << bus.up_s) - W'(1);
    bias = '0;
    case (bus.up_mode)
      MODE_TRUNC: if (bus.up_a[N-1]) bias = mask;
      MODE_ROUND: bias = (W'(1) << bus.up_s) >> 1;  // 0 when s == 0
      default:    bias = '0;                        // FLOOR and reserved
    endcase
    p_d.val     = {bus.up_a[N-1], bus.up_a} + bias;
    p_d.s       = bus.up_s;
    p_d.inexact = |(bus.up_a & mask[N-1:0]);
  end

  assign up_rdy       = !p_vld_q || rdy[0];
  assign bus.up_ready = up_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld_q <= 1'b0;
      p_q     <= '0;
    end else if (up_rdy) begin
      p_vld_q <= bus.up_valid;
      if (bus.up_valid) p_q <= p_d;
    end
  end

  assign vld_pipe[0] = p_vld_q;
  assign pl[0]       = p_q;
  assign rdy[SW]     = bus.down_ready;

  for (genvar k = 0; k < SW; k++) begin : g_shift
    pow2_div_shift_stage #(
      .W     (W),
      .SHIFT (1 << k),
      .SW    (SW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (vld_pipe[k]),
      .in_ready_o  (rdy[k]),
      .in_pl_i     (pl[k]),
      .out_valid_o (vld_pipe[k+1]),
      .out_ready_i (rdy[k+1]),
      .out_pl_o    (pl[k+1])
    );
  end

  assign bus.down_valid   = vld_pipe[SW];
  assign bus.down_res     = pl[SW].val[N-1:0];
  assign bus.down_inexact = pl[SW].inexact;

  // extension bit and carried shift are dead after the last stage
  logic unused_tail;
  assign unused_tail = ^{pl[SW].val[N], pl[SW].s};
endmodule

// File: tb/tb_signed_pow2_divide_pipe.sv
module tb_signed_pow2_divide_pipe;
  localparam int N = 8;
  localparam int CAP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  signed_pow2_divide_pipe_if #(.N(N)) bus ();
  signed_pow2_divide_pipe #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int nchk = 0;
  int errs = 0;
  int full_seen = 0;
  bit bp_rand = 1'b0;
  logic [8:0] sb[$];
  bit stall_q = 1'b0;
  logic [8:0] held;

  // floor division on plain integers
  function automatic int fdiv(input int x, input int d);
    int q;
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  // golden model: returns {inexact, res[7:0]}
  function automatic logic [8:0] model(input logic [7:0] a, input int s, input int mode);
    int av, d, q;
    av = $signed(a);
    d  = 1 << s;
    case (mode)
      1:       q = av / d;
      2:       q = fdiv(av + d / 2, d);
      default: q = fdiv(av, d);
    endcase
    return {((av % d) != 0), q[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // compare process: scoreboard, ready rule, stall stability
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      sb.delete();
      stall_q = 1'b0;
    end else begin
      nchk++;
      if (bus.up_ready !== ((sb.size() < CAP) || bus.down_ready)) begin
        errs++;
        $display("FAIL up_ready got %b occ %0d down_ready %b", bus.up_ready, sb.size(), bus.down_ready);
      end
      if (!bus.up_ready) full_seen++;
      if (stall_q) begin
        nchk++;
        if (bus.down_valid !== 1'b1 || {bus.down_inexact, bus.down_res} !== held) begin
          errs++;
          $display("FAIL stall_hold got v=%b %h want %h", bus.down_valid, {bus.down_inexact, bus.down_res}, held);
        end
      end
      if (bus.down_valid && bus.down_ready) begin
        nchk++;
        if (sb.size() == 0) begin
          errs++;
          $display("FAIL unexpected_result got %h", {bus.down_inexact, bus.down_res});
        end else begin
          e = sb.pop_front();
          if ({bus.down_inexact, bus.down_res} !== e) begin
            errs++;
            $display("FAIL result got %h want %h", {bus.down_inexact, bus.down_res}, e);
          end
        end
      end
      if (bus.up_valid && bus.up_ready)
        sb.push_back(model(bus.up_a, int'(bus.up_s), int'(bus.up_mode)));
      stall_q = bus.down_valid && !bus.down_ready;
      held = {bus.down_inexact, bus.down_res};
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (bp_rand) bus.down_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // present an operand and hold it until accepted; called at posedge+1
  task automatic send(input logic [7:0] a, input logic [2:0] s, input logic [1:0] m);
    bit ok;
    int n;
    n = 0;
    bus.up_valid = 1'b1; bus.up_a = a; bus.up_s = s; bus.up_mode = m;
    do begin
      @(negedge clk); ok = bus.up_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [7:0] a, input logic [2:0] s,
                          input logic [1:0] m, input logic [7:0] er, input logic ei);
    int lat;
    send(a, s, m);
    bus.up_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.down_valid && lat < 20);
    chk({name, "_lat"}, lat, 4);
    chk({name, "_res"}, bus.down_res, er);
    chk({name, "_inx"}, bus.down_inexact, ei);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int fs0;
    bus.up_valid = 0; bus.up_a = '0; bus.up_s = '0; bus.up_mode = '0; bus.down_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_down_valid", bus.down_valid, 0);
    chk("rst_down_res", bus.down_res, 0);
    chk("rst_down_inx", bus.down_inexact, 0);
    chk("rst_up_ready", bus.up_ready, 1);
    @(posedge clk); #1;

    // pin the model itself
    chk("model_floor", model(8'hF3, 2, 0), 9'h1FC);
    chk("model_trunc", model(8'hF3, 2, 1), 9'h1FD);
    chk("model_round", model(8'h7F, 1, 2), 9'h140);
    chk("model_s0", model(8'hA5, 0, 2), 9'h0A5);

    directed("m13_floor", 8'hF3, 3'd2, 2'd0, 8'hFC, 1'b1);
    directed("m13_trunc", 8'hF3, 3'd2, 2'd1, 8'hFD, 1'b1);
    directed("m13_round", 8'hF3, 3'd2, 2'd2, 8'hFD, 1'b1);
    directed("m13_rsvd",  8'hF3, 3'd2, 2'd3, 8'hFC, 1'b1);
    directed("m128_floor", 8'h80, 3'd7, 2'd0, 8'hFF, 1'b0);
    directed("m128_trunc", 8'h80, 3'd7, 2'd1, 8'hFF, 1'b0);
    directed("m128_round", 8'h80, 3'd7, 2'd2, 8'hFF, 1'b0);
    directed("m1_floor", 8'hFF, 3'd3, 2'd0, 8'hFF, 1'b1);
    directed("m1_trunc", 8'hFF, 3'd3, 2'd1, 8'h00, 1'b1);
    directed("m1_round", 8'hFF, 3'd3, 2'd2, 8'h00, 1'b1);
    directed("p127_floor", 8'h7F, 3'd1, 2'd0, 8'h3F, 1'b1);
    directed("p127_trunc", 8'h7F, 3'd1, 2'd1, 8'h3F, 1'b1);
    directed("p127_round", 8'h7F, 3'd1, 2'd2, 8'h40, 1'b1);
    for (int m = 0; m < 4; m++)
      directed("s0", 8'hA5, 3'd0, m[1:0], 8'hA5, 1'b0);

    // back-pressure: 10 back-to-back operands, down_ready low on cycles 3..8
    fs0 = full_seen;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(i * 29 + 3), 3'(i % 8), 2'(i % 3));
        bus.up_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          bus.down_ready = !(c >= 3 && c <= 8);
          @(posedge clk); #1;
        end
      end
    join
    bus.down_ready = 1'b1;
    drain();
    chk("flow_full_seen", (full_seen > fs0), 1);

    // reset with two operands in flight
    bus.down_ready = 1'b0;
    send(8'h55, 3'd1, 2'd0);
    send(8'hAA, 3'd2, 2'd1);
    bus.up_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.down_ready = 1'b1;
    @(negedge clk);
    chk("midrst_down_valid", bus.down_valid, 0);
    chk("midrst_down_res", bus.down_res, 0);
    chk("midrst_up_ready", bus.up_ready, 1);
    repeat (10) @(posedge clk);
    #1;

    // random traffic with random back-pressure
    bp_rand = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      send(8'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) begin
        bus.up_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.up_valid = 1'b0;
    bp_rand = 1'b0;
    bus.down_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
    $finish;
  end
endmodule
